seq_det_ctrl: RTL and testbench

- Word-level controller for the serial pattern-detection path.
- Accepts a parallel word and a programmable pattern over a valid/ready handshake, then serializes the word MSB-first, one bit per clock, into a window matcher.
- Counts overlapping pattern matches within the word and returns the result over a second valid/ready handshake.
- Sits between a parallel producer (CPU/UART word buffer) and the result consumer.

---
 rtl/seq_det_pkg.sv | 15 +
 rtl/seq_pat_match.sv | 47 ++++
 rtl/seq_det_ctrl.sv | 154 +++++++++++++++
 tb/tb_seq_det_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared FSM encoding and default geometry for the serial pattern-detection controller.
package seq_det_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_PAT_W  = 4;
    localparam int DEF_CNT_W  = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/seq_pat_match.sv
// Sliding-window matcher: keeps the last PAT_W bits of the current word and raises a
// registered match_r one cycle after the bit that completes the pattern.
module seq_pat_match
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             bit_en,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    output logic             match_r
);

    localparam int NB_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] window;
    logic [NB_W-1:0]  nbits;
    logic             fresh;

    // fresh marks a window that just took a new bit, so each bit can match at most once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            window  <= '0;
            nbits   <= '0;
            fresh   <= 1'b0;
            match_r <= 1'b0;
        end else if (clr) begin
            window  <= '0;
            nbits   <= '0;
            fresh   <= 1'b0;
            match_r <= 1'b0;
        end else begin
            fresh   <= bit_en;
            match_r <= fresh && (nbits == NB_W'(PAT_W)) && (window == pattern);
            if (bit_en) begin
                window <= {window[PAT_W-2:0], bit_in};
                if (nbits != NB_W'(PAT_W)) begin
                    nbits <= nbits + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seq_det_ctrl.sv
// Word-level pattern detector: accepts a word and pattern, scans the word MSB-first and
// returns a saturating match count. Define SEQ_DET_CTRL_FIRST_POS_EN to add first_pos.
module seq_det_ctrl
    import seq_det_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PAT_W  = DEF_PAT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic [PAT_W-1:0]          in_pattern,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          match_count,
    output logic                      first_hit
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
    ,
    output logic [$clog2(DATA_W)-1:0] first_pos
`endif
);

    localparam int IDX_W = $clog2(DATA_W + 1);

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] shift_reg;
    logic [PAT_W-1:0]  pat_reg;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  count;
    logic              hit;
    logic              match_r;
    logic              accept;
    logic              bit_en;
    logic              count_en;

    assign accept   = in_valid && in_ready;
    assign bit_en   = (state == SHIFT) && (idx != IDX_W'(DATA_W));
    assign count_en = match_r && busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // SHIFT spends one extra cycle at idx == DATA_W so the last bit's match_r is in flight
    // before DRAIN counts it
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (idx == IDX_W'(DATA_W)) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            pat_reg   <= '0;
            idx       <= '0;
            count     <= '0;
            hit       <= 1'b0;
        end else if (accept) begin
            shift_reg <= in_data;
            pat_reg   <= in_pattern;
            idx       <= '0;
            count     <= '0;
            hit       <= 1'b0;
        end else begin
            if (bit_en) begin
                shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                idx       <= idx + 1'b1;
            end
            if (count_en) begin
                hit <= 1'b1;
                if (count != '1) begin
                    count <= count + 1'b1;
                end
            end
        end
    end

`ifdef SEQ_DET_CTRL_FIRST_POS_EN
    localparam int POS_W = $clog2(DATA_W);

    logic [POS_W-1:0] pend_pos;
    logic [POS_W-1:0] pos;

    // pend_pos tracks the index of the bit that the current match_r refers to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_pos <= '0;
            pos      <= '0;
        end else if (accept) begin
            pend_pos <= '0;
            pos      <= '0;
        end else begin
            pend_pos <= POS_W'(idx - IDX_W'(1));
            if (count_en && !hit) begin
                pos <= pend_pos;
            end
        end
    end

    assign first_pos = pos;
`endif

    seq_pat_match #(
        .PAT_W(PAT_W)
    ) u_match (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept),
        .bit_en  (bit_en),
        .bit_in  (shift_reg[DATA_W-1]),
        .pattern (pat_reg),
        .match_r (match_r)
    );

    assign match_count = count;
    assign first_hit   = hit;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Scoreboard bench for seq_det_ctrl: a default instance and a CNT_W=3 instance share stimulus;
// expectations come from a window-scan model. Honours SEQ_DET_CTRL_FIRST_POS_EN.
module tb_seq_det_ctrl;

    localparam int DATA_W = 16;
    localparam int PAT_W  = 4;
    localparam int CNT_W  = 5;
    localparam int SAT_W  = 3;
    localparam int POS_W  = $clog2(DATA_W);

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [PAT_W-1:0]  in_pattern;
    logic              out_ready;

    logic              in_ready, busy, out_valid, first_hit;
    logic [CNT_W-1:0]  match_count;
    logic              s_in_ready, s_busy, s_out_valid, s_first_hit;
    logic [SAT_W-1:0]  s_match_count;
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
    logic [POS_W-1:0]  first_pos, s_first_pos;
`endif

    typedef struct {
        int     cnt;
        int     sat;
        int     hit;
        int     pos;
        longint acc;
    } exp_t;

    exp_t   exp_q[$];
    int     checks;
    int     errors;
    longint cyc;
    logic   prev_ov;
    int     hold_cnt, hold_hit, hold_pos;

    seq_det_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_pattern  (in_pattern),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .match_count (match_count),
        .first_hit   (first_hit)
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
        ,
        .first_pos   (first_pos)
`endif
    );

    seq_det_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(SAT_W)) u_sat (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (s_in_ready),
        .in_data     (in_data),
        .in_pattern  (in_pattern),
        .busy        (s_busy),
        .out_valid   (s_out_valid),
        .out_ready   (out_ready),
        .match_count (s_match_count),
        .first_hit   (s_first_hit)
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
        ,
        .first_pos   (s_first_pos)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    // Count every PAT_W-bit slice of the word (bit 0 = MSB) equal to the pattern
    function automatic void model(input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p,
                                  output int cnt, output int pos);
        logic [PAT_W-1:0] w;
        cnt = 0;
        pos = 0;
        for (int i = PAT_W - 1; i < DATA_W; i++) begin
            for (int k = 0; k < PAT_W; k++) begin
                w[PAT_W-1-k] = d[DATA_W-1-(i-PAT_W+1+k)];
            end
            if (w == p) begin
                if (cnt == 0) pos = i;
                cnt++;
            end
        end
    endfunction

    // Scoreboard push on every accepted word
    always @(posedge clk) begin
        int   c, p;
        exp_t e;
        if (reset && in_valid && in_ready) begin
            model(in_data, in_pattern, c, p);
            e.cnt = c;
            e.sat = (c > (2**SAT_W - 1)) ? (2**SAT_W - 1) : c;
            e.hit = (c > 0) ? 1 : 0;
            e.pos = p;
            e.acc = cyc;
            exp_q.push_back(e);
        end
        cyc <= cyc + 1;
    end

    // Monitor: latency on rise, stability while held, values at hand-off
    always @(negedge clk) begin
        if (!reset) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_out_valid", out_valid, 0);
                end else begin
                    check_output("latency", int'(cyc - 1 - exp_q[0].acc), DATA_W + 2);
                    check_output("sat_out_valid", s_out_valid, 1);
                end
            end else if (out_valid) begin
                check_output("stable_count", match_count, hold_cnt);
                check_output("stable_hit", first_hit, hold_hit);
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
                check_output("stable_pos", first_pos, hold_pos);
`endif
            end
            hold_cnt = match_count;
            hold_hit = first_hit;
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
            hold_pos = first_pos;
`endif
            if (out_valid && out_ready && exp_q.size() > 0) begin
                check_output("match_count", match_count, exp_q[0].cnt);
                check_output("first_hit", first_hit, exp_q[0].hit);
                check_output("sat_match_count", s_match_count, exp_q[0].sat);
                check_output("sat_first_hit", s_first_hit, exp_q[0].hit);
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
                check_output("first_pos", first_pos, exp_q[0].pos);
`endif
                void'(exp_q.pop_front());
            end
            prev_ov = out_valid;
        end
    end

    task automatic apply_stimulus(input logic [DATA_W-1:0] d, input logic [PAT_W-1:0] p,
                                  input int stall);
        int n;
        in_data    = d;
        in_pattern = p;
        in_valid   = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("accept_wait", in_ready, 1);
        @(posedge clk); #1;
        in_valid   = 1'b0;
        in_data    = DATA_W'($urandom);
        in_pattern = PAT_W'($urandom);
        check_output("busy_after_accept", busy, 1);
        check_output("in_ready_while_busy", in_ready, 0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < DATA_W + 10) begin
            @(posedge clk); #1;
            n++;
        end
        check_output("result_wait", out_valid, 1);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check_output("stall_out_valid", out_valid, 1);
            check_output("stall_in_ready", in_ready, 0);
            check_output("stall_busy", busy, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_output("in_ready_after_handoff", in_ready, 1);
        check_output("out_valid_after_handoff", out_valid, 0);
    endtask

    initial begin
        logic [PAT_W-1:0]  p;
        logic [DATA_W-1:0] d;
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        prev_ov    = 1'b0;
        hold_cnt   = 0;
        hold_hit   = 0;
        hold_pos   = 0;
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_pattern = '0;
        out_ready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_in_ready", in_ready, 1);
        check_output("reset_busy", busy, 0);
        check_output("reset_out_valid", out_valid, 0);
        check_output("reset_count", match_count, 0);
        check_output("reset_hit", first_hit, 0);
`ifdef SEQ_DET_CTRL_FIRST_POS_EN
        check_output("reset_pos", first_pos, 0);
`endif
        reset = 1'b1;
        @(posedge clk); #1;

        apply_stimulus(16'b1101101101101101, 4'b1101, 0);
        apply_stimulus(16'h0000, 4'b1101, 0);
        apply_stimulus(16'hFFFF, 4'b1111, 0);
        apply_stimulus(16'hB6DB, 4'b1011, 10);

        // Abort a word mid-scan with an asynchronous reset
        in_data    = DATA_W'($urandom);
        in_pattern = PAT_W'($urandom);
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check_output("busy_before_abort", busy, 1);
        reset = 1'b0;
        #1;
        exp_q.delete();
        check_output("abort_in_ready", in_ready, 1);
        check_output("abort_busy", busy, 0);
        check_output("abort_out_valid", out_valid, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < DATA_W + 4; i++) begin
            @(posedge clk); #1;
            check_output("no_result_after_abort", out_valid, 0);
        end

        apply_stimulus(16'h000D, 4'b1101, 0);
        apply_stimulus(16'hA000, 4'b1101, 0);

        for (int t = 0; t < 40; t++) begin
            p = PAT_W'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                d = {(DATA_W / PAT_W){p}} ^ (DATA_W'($urandom) & DATA_W'($urandom) & DATA_W'($urandom));
            end else begin
                d = DATA_W'($urandom);
            end
            apply_stimulus(d, p, $urandom_range(0, 3));
        end

        check_output("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
